// File: rtl/sc_imem_boot_loader.sv
// rtl/sc_imem_boot_loader.sv - boot loader that fills instruction memory from a byte stream
// Holds the CPU stalled until N little-endian words have been written from address 0 upward.
module sc_imem_boot_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reload,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [31:0]           imem_wr_data,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [31:0] word_count;
    logic [31:0] idle_cnt;
    logic [31:0] full;
    logic        accept;
    logic        idle_active;
    logic        timed_out;

    assign in_ready    = (state == S_LEN || state == S_DATA) && !reload;
    assign accept      = in_valid && in_ready;
    assign full        = {in_data, shift};
    // The idle clock only runs once a load has actually started.
    assign idle_active = (state == S_DATA) || (state == S_LEN && byte_cnt != 2'd0);
    assign timed_out   = (TIMEOUT_CYCLES != 0) && idle_active && !accept
                         && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_LEN;
            byte_cnt     <= 2'd0;
            shift        <= '0;
            word_count   <= '0;
            idle_cnt     <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_run      <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else if (reload) begin
            state        <= S_LEN;
            byte_cnt     <= 2'd0;
            shift        <= '0;
            word_count   <= '0;
            idle_cnt     <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_run      <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_wr_en <= 1'b0;
            if (accept) begin
                idle_cnt <= '0;
            end else if (idle_active) begin
                idle_cnt <= idle_cnt + 32'd1;
            end

            case (state)
                S_LEN: begin
                    if (timed_out) begin
                        state      <= S_ERR;
                        load_error <= 1'b1;
                    end else if (accept) begin
                        shift    <= full[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_count <= full;
                            if (full == 32'd0 || {1'b0, full} > DEPTH) begin
                                state      <= S_ERR;
                                load_error <= 1'b1;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    // Release the CPU only after the last write pulse has been seen.
                    if (imem_wr_en && 32'(words_loaded) == word_count) begin
                        state     <= S_DONE;
                        cpu_run   <= 1'b1;
                        load_done <= 1'b1;
                    end else if (timed_out) begin
                        state      <= S_ERR;
                        load_error <= 1'b1;
                    end else if (accept) begin
                        shift    <= full[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_wr_en   <= 1'b1;
                            imem_wr_addr <= words_loaded[ADDR_WIDTH-1:0];
                            imem_wr_data <= full;
                            words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sc_imem_boot_loader.sv
// tb/tb_sc_imem_boot_loader.sv - self-checking bench for sc_imem_boot_loader
// A byte-queue reference model is compared against the DUT on every falling edge.
module tb_sc_imem_boot_loader;
    localparam int AW    = 10;
    localparam int TO    = 8;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reload = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          cpu_run;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    sc_imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .reload(reload), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data), .cpu_run(cpu_run), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes accepted since the last reset/reload drive everything.
    logic [7:0]  q[$];
    int          idle = 0;
    bit          m_err = 0;
    bit          m_done = 0;
    bit          m_wr = 0;
    int          m_addr = 0;
    logic [31:0] m_data = 0;
    int          m_wl = 0;
    longint      m_n = -1;

    function automatic logic [31:0] le32(input int b);
        return {q[b+3], q[b+2], q[b+1], q[b]};
    endfunction

    task automatic model_clear();
        q.delete();
        idle = 0; m_err = 0; m_done = 0; m_wr = 0;
        m_addr = 0; m_data = 0; m_wl = 0; m_n = -1;
    endtask

    task automatic model_step();
        bit nwr;
        int k;
        nwr = 0;
        if (!m_err && !m_done) begin
            if (m_wr && m_wl == m_n) begin
                m_done = 1;
            end else if (in_valid) begin
                q.push_back(in_data);
                idle = 0;
                if (q.size() == 4) begin
                    m_n = longint'(le32(0));
                    if (m_n == 0 || m_n > DEPTH) m_err = 1;
                end else if (q.size() > 4 && q.size() % 4 == 0) begin
                    k = (q.size() - 4) / 4;
                    if (k <= m_n) begin
                        nwr = 1; m_addr = k - 1; m_data = le32(4 * k); m_wl = k;
                    end
                end
            end else if (q.size() > 0) begin
                idle++;
                if (idle >= TO) m_err = 1;
            end
        end
        m_wr = nwr;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset || reload) model_clear();
        else model_step();
    end

    logic [31:0] mem [0:DEPTH-1];
    int          wr_seen = 0;

    always @(negedge clk) begin
        chk("in_ready", in_ready, !m_err && !m_done && !reload);
        chk("imem_wr_en", imem_wr_en, m_wr);
        chk("imem_wr_addr", imem_wr_addr, m_addr);
        chk("imem_wr_data", imem_wr_data, m_data);
        chk("cpu_run", cpu_run, m_done);
        chk("load_done", load_done, m_done);
        chk("load_error", load_error, m_err);
        chk("words_loaded", words_loaded, m_wl);
        if (imem_wr_en === 1'b1) begin
            mem[imem_wr_addr] = imem_wr_data;
            wr_seen++;
        end
    end

    task automatic step(input bit v, input logic [7:0] d, input bit rl);
        in_valid = v; in_data = d; reload = rl;
        @(negedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) step(1'b1, w[8*i +: 8], 1'b0);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    int          cyc;
    int          wcyc[$];
    int          kind, gap, nw, abort_at, to_at;
    logic [31:0] n;
    logic [31:0] prog[8];
    logic [7:0]  stream[$];

    initial begin : main
        #2 reset = 1'b0;
        idle_steps(2);
        chk("rst_wr_en", imem_wr_en, 0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        idle_steps(1);

        // Single word load
        send32(32'h1);
        send32(32'h12345678);
        chk("t1_wr_en", imem_wr_en, 1);
        chk("t1_addr", imem_wr_addr, 0);
        chk("t1_data", imem_wr_data, 32'h12345678);
        idle_steps(1);
        chk("t1_cpu_run", cpu_run, 1);
        chk("t1_done", load_done, 1);
        chk("t1_in_ready", in_ready, 0);

        // Three words back to back: write cycles 9, 13, 17
        step(1'b0, 8'h00, 1'b1);
        cyc = 0;
        wcyc.delete();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            w = (i < 4) ? 32'd3 : 32'hA0B0C000 + 32'(i / 4);
            step(1'b1, w[8*(i%4) +: 8], 1'b0);
            cyc++;
            if (imem_wr_en) wcyc.push_back(cyc + 1);
        end
        for (int i = 0; i < 10 && !load_done; i++) step(1'b0, 8'h00, 1'b0);
        chk("t2_nwrites", wcyc.size(), 3);
        if (wcyc.size() == 3) begin
            chk("t2_cyc0", wcyc[0], 9);
            chk("t2_cyc1", wcyc[1], 13);
            chk("t2_cyc2", wcyc[2], 17);
        end
        chk("t2_words", words_loaded, 3);
        chk("t2_mem2", mem[2], 32'hA0B0C003);

        // Bad lengths
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 8'h00, 1'b1);
            wr_seen = 0;
            send32(t == 0 ? 32'd0 : (t == 1 ? 32'd1025 : 32'hFFFFFFFF));
            chk("t3_err", load_error, 1);
            chk("t3_in_ready", in_ready, 0);
            send32(32'hCAFEF00D);
            chk("t3_no_wr", wr_seen, 0);
        end

        // Reload mid-load, then fresh single-word load
        step(1'b0, 8'h00, 1'b1);
        send32(32'd3); send32(32'h11111111); send32(32'h22222222);
        step(1'b1, 8'h33, 1'b0); step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h33, 1'b1);
        wr_seen = 0;
        send32(32'd1); send32(32'hDDCCBBAA);
        idle_steps(2);
        chk("t4_writes", wr_seen, 1);
        chk("t4_mem0", mem[0], 32'hDDCCBBAA);
        chk("t4_words", words_loaded, 1);
        chk("t4_done", load_done, 1);

        // Timeout: 8 idle cycles fail, 7 pass
        for (int s = 8; s >= 7; s--) begin
            step(1'b0, 8'h00, 1'b1);
            send32(32'd2); send32(32'h01020304);
            step(1'b1, 8'h05, 1'b0); step(1'b1, 8'h06, 1'b0);
            idle_steps(s);
            step(1'b1, 8'h07, 1'b0); step(1'b1, 8'h08, 1'b0);
            idle_steps(2);
            chk(s == 8 ? "t5_err8" : "t5_err7", load_error, s == 8);
            chk(s == 8 ? "t5_done8" : "t5_done7", load_done, s == 7);
        end

        // Asynchronous reset while a write pulse is up
        step(1'b0, 8'h00, 1'b1);
        send32(32'd2); send32(32'h5A5A5A5A);
        chk("t6_pre_wr", imem_wr_en, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_wr_en", imem_wr_en, 0);
        chk("t6_addr", imem_wr_addr, 0);
        chk("t6_data", imem_wr_data, 0);
        chk("t6_cpu_run", cpu_run, 0);
        chk("t6_words", words_loaded, 0);
        chk("t6_err", load_error, 0);
        step(1'b0, 8'h00, 1'b0);
        reset = 1'b1;

        // Randomized loads
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) n = 32'd0;
            else if (kind == 1) n = ($urandom_range(0, 1) == 0) ? 32'd1025 : ($urandom | 32'h80000000);
            else n = 32'($urandom_range(1, 6));
            nw = (kind <= 1) ? 1 : int'(n);
            stream.delete();
            for (int b = 0; b < 4; b++) stream.push_back(n[8*b +: 8]);
            for (int w = 0; w < nw; w++) begin
                prog[w] = $urandom;
                for (int b = 0; b < 4; b++) stream.push_back(prog[w][8*b +: 8]);
            end
            for (int i = 0; i < 8; i++) mem[i] = 32'hDEADBEEF;
            abort_at = (kind == 3) ? $urandom_range(1, stream.size() - 1) : -1;
            to_at    = (kind == 2) ? $urandom_range(1, stream.size() - 1) : -1;
            step(1'b1, 8'($urandom), 1'b1);
            for (int i = 0; i < stream.size(); i++) begin
                if (i == abort_at) begin
                    step(1'b1, 8'($urandom), 1'b1);
                    break;
                end
                gap = (i == to_at) ? $urandom_range(8, 10)
                    : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0);
                step(1'b1, stream[i], 1'b0);
            end
            idle_steps(4);
            if (kind >= 4) begin
                chk("rnd_done", load_done, 1);
                for (int w = 0; w < nw; w++) chk("rnd_mem", mem[w], prog[w]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
